// File: rtl/serdesphy_cdr_pkg.sv
// Shared types and helpers for the receive CDR controller.
//   cdr_state_e : controller FSM states, encodings visible on the debug port
//   CDR_CTRL_W  : width of the VCO control word
//   sat_add8    : adds a signed step to the control word, clamping at 0 and 255
package serdesphy_cdr_pkg;

  localparam int CDR_CTRL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_FAULT   = 3'd4
  } cdr_state_e;

  // The sum is formed one bit wider than needed so both overflow directions
  // are visible before clamping; the word never wraps.
  function automatic logic [CDR_CTRL_W-1:0] sat_add8(
    input logic [CDR_CTRL_W-1:0] value,
    input logic signed [8:0]     step
  );
    logic signed [9:0] sum;
    sum = $signed({2'b00, value}) + $signed({step[8], step});
    if (sum < 10'sd0) begin
      return '0;
    end else if (sum > 10'sd255) begin
      return '1;
    end else begin
      return sum[CDR_CTRL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/serdesphy_sync2.sv
// Generic two-flop synchroniser for asynchronous level signals.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronised output, two cycles behind d
module serdesphy_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serdesphy_cdr_ctrl.sv
// Receive CDR VCO controller: sequences VCO startup, steers the control word
// from phase-detector votes and tracks lock over fixed vote windows.
// Optional build macro SERDESPHY_CDR_FREEZE_EN adds the cdr_freeze input,
// which holds the loop (control word, window, vote and quiet counters).
//   clk, rst     : clock and asynchronous active-high reset
//   cdr_en       : loop enable level; low forces IDLE on the next edge
//   pd_up, pd_dn : phase-detector early/late votes
//   vco_ready    : asynchronous VCO-stable flag
//   cdr_freeze   : (optional) hold the loop while high
//   vco_enable, cdr_control, cdr_locked, cdr_fault : registered outputs
//   state        : current FSM state for debug
// Handshake: there is no valid/ready pair here; votes are sampled every
// cycle and vco_ready is treated as a level after synchronisation.
module serdesphy_cdr_ctrl
  import serdesphy_cdr_pkg::*;
#(
  parameter int unsigned CENTER        = 128,
  parameter int unsigned ACQ_STEP      = 4,
  parameter int unsigned TRK_STEP      = 1,
  parameter int unsigned WIN_LEN       = 64,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter int unsigned UNLOCK_THRESH = 16,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cdr_en,
  input  logic                  pd_up,
  input  logic                  pd_dn,
  input  logic                  vco_ready,
`ifdef SERDESPHY_CDR_FREEZE_EN
  input  logic                  cdr_freeze,
`endif
  output logic                  vco_enable,
  output logic [CDR_CTRL_W-1:0] cdr_control,
  output logic                  cdr_locked,
  output logic                  cdr_fault,
  output logic [2:0]            state
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int NET_W = WIN_W + 2;
  localparam int TMO_W = $clog2(READY_TIMEOUT);
  localparam int QW    = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CDR_CTRL_W-1:0] CENTER_W = CDR_CTRL_W'(CENTER);

  logic freeze;
`ifdef SERDESPHY_CDR_FREEZE_EN
  assign freeze = cdr_freeze;
`else
  assign freeze = 1'b0;
`endif

  logic rdy_s;
  serdesphy_sync2 #(.W(1)) u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d   (vco_ready),
    .q   (rdy_s)
  );

  cdr_state_e             state_q, state_d;
  logic [CDR_CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic                   locked_q, locked_d, fault_q, fault_d, vco_en_q, vco_en_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic signed [NET_W-1:0] net_q, net_d;
  logic [QW-1:0]          quiet_q, quiet_d;

  logic                   up_only, dn_only, win_end, quiet_win, loud_win;
  logic signed [NET_W-1:0] vote, net_sum, net_abs;
  logic signed [8:0]      step_mag, step;
  logic [QW-1:0]          quiet_inc;

  assign up_only = pd_up & ~pd_dn;
  assign dn_only = pd_dn & ~pd_up;
  assign vote    = up_only ? NET_W'(1) : (dn_only ? {NET_W{1'b1}} : '0);
  // The end-cycle vote is folded in before judging the window.
  assign net_sum   = net_q + vote;
  assign net_abs   = net_sum[NET_W-1] ? -net_sum : net_sum;
  assign win_end   = (win_q == WIN_W'(WIN_LEN - 1));
  assign quiet_win = (net_abs <= $signed(NET_W'(LOCK_THRESH)));
  assign loud_win  = (net_abs >= $signed(NET_W'(UNLOCK_THRESH)));
  assign quiet_inc = quiet_q + QW'(1);
  assign step_mag  = (state_q == ST_TRACK) ? 9'(TRK_STEP) : 9'(ACQ_STEP);
  assign step      = up_only ? step_mag : (dn_only ? -step_mag : 9'sd0);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    vco_en_d = vco_en_q;
    tmo_d    = tmo_q;
    win_d    = win_q;
    net_d    = net_q;
    quiet_d  = quiet_q;
    if (!cdr_en) begin
      state_d  = ST_IDLE;
      ctrl_d   = CENTER_W;
      locked_d = 1'b0;
      fault_d  = 1'b0;
      vco_en_d = 1'b0;
      tmo_d    = '0;
      win_d    = '0;
      net_d    = '0;
      quiet_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_START;
          vco_en_d = 1'b1;
          ctrl_d   = CENTER_W;
          tmo_d    = '0;
        end
        ST_START: begin
          vco_en_d = 1'b1;
          if (rdy_s) begin
            state_d = ST_ACQUIRE;
            win_d   = '0;
            net_d   = '0;
            quiet_d = '0;
          end else if (tmo_q == TMO_W'(READY_TIMEOUT - 1)) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            vco_en_d = 1'b0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_ACQUIRE, ST_TRACK: begin
          if (!rdy_s) begin
            state_d  = ST_START;
            locked_d = 1'b0;
            ctrl_d   = CENTER_W;
            tmo_d    = '0;
          end else if (!freeze) begin
            ctrl_d = sat_add8(ctrl_q, step);
            win_d  = win_q + WIN_W'(1);
            if (win_end) begin
              net_d = '0;
              if (state_q == ST_ACQUIRE) begin
                if (!quiet_win) begin
                  quiet_d = '0;
                end else if (quiet_inc == QW'(LOCK_WINDOWS)) begin
                  state_d  = ST_TRACK;
                  locked_d = 1'b1;
                  quiet_d  = '0;
                end else begin
                  quiet_d = quiet_inc;
                end
              end else if (loud_win) begin
                state_d  = ST_ACQUIRE;
                locked_d = 1'b0;
                quiet_d  = '0;
              end
            end else begin
              net_d = net_sum;
            end
          end
        end
        ST_FAULT: begin
          fault_d  = 1'b1;
          vco_en_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= CENTER_W;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      vco_en_q <= 1'b0;
      tmo_q    <= '0;
      win_q    <= '0;
      net_q    <= '0;
      quiet_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      vco_en_q <= vco_en_d;
      tmo_q    <= tmo_d;
      win_q    <= win_d;
      net_q    <= net_d;
      quiet_q  <= quiet_d;
    end
  end

  assign vco_enable  = vco_en_q;
  assign cdr_control = ctrl_q;
  assign cdr_locked  = locked_q;
  assign cdr_fault   = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_serdesphy_cdr_ctrl.sv
// Self-checking bench for serdesphy_cdr_ctrl with a cycle-level behavioural
// model (phase numbers, integer control value, per-window vote queue).
module tb_serdesphy_cdr_ctrl;

  localparam int CENTER        = 128;
  localparam int ACQ_STEP      = 4;
  localparam int TRK_STEP      = 1;
  localparam int WIN_LEN       = 64;
  localparam int LOCK_THRESH   = 4;
  localparam int LOCK_WINDOWS  = 4;
  localparam int UNLOCK_THRESH = 16;
  localparam int READY_TIMEOUT = 1024;
  localparam int W             = 14;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cdr_en = 1'b0, pd_up = 1'b0, pd_dn = 1'b0, vco_ready = 1'b0;
`ifdef SERDESPHY_CDR_FREEZE_EN
  logic       cdr_freeze = 1'b0;
`endif
  logic       vco_enable, cdr_locked, cdr_fault;
  logic [7:0] cdr_control;
  logic [2:0] state;

  serdesphy_cdr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cdr_en      (cdr_en),
    .pd_up       (pd_up),
    .pd_dn       (pd_dn),
    .vco_ready   (vco_ready),
`ifdef SERDESPHY_CDR_FREEZE_EN
    .cdr_freeze  (cdr_freeze),
`endif
    .vco_enable  (vco_enable),
    .cdr_control (cdr_control),
    .cdr_locked  (cdr_locked),
    .cdr_fault   (cdr_fault),
    .state       (state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int m_phase = 0;      // 0 idle, 1 start, 2 acquire, 3 track, 4 fault
  int m_ctrl = CENTER;
  int m_wait = 0;
  int m_quiet = 0;
  bit m_locked = 0, m_fault = 0, m_vco = 0;
  bit sync_a = 0, sync_b = 0;
  int win_votes[$];

  logic [W-1:0] exp_q[$];

  function automatic int clamp255(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ctrl = CENTER; m_wait = 0; m_quiet = 0;
    m_locked = 0; m_fault = 0; m_vco = 0; sync_a = 0; sync_b = 0;
    win_votes.delete();
  endtask

  task automatic model_step();
    bit rdy, frozen;
    int v, s, mag;
    if (rst) begin
      model_reset();
      return;
    end
    rdy = sync_b;
    sync_b = sync_a;
    sync_a = vco_ready;
`ifdef SERDESPHY_CDR_FREEZE_EN
    frozen = cdr_freeze;
`else
    frozen = 0;
`endif
    v = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
    if (!cdr_en) begin
      m_phase = 0; m_ctrl = CENTER; m_locked = 0; m_fault = 0; m_vco = 0;
      m_wait = 0; m_quiet = 0; win_votes.delete();
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_vco = 1; m_wait = 0; m_ctrl = CENTER; end
        1: begin
          if (rdy) begin
            m_phase = 2; m_quiet = 0; win_votes.delete();
          end else if (m_wait == READY_TIMEOUT - 1) begin
            m_phase = 4; m_fault = 1; m_vco = 0;
          end else begin
            m_wait++;
          end
        end
        2, 3: begin
          if (!rdy) begin
            m_phase = 1; m_locked = 0; m_ctrl = CENTER; m_wait = 0;
          end else if (!frozen) begin
            mag = (m_phase == 2) ? ACQ_STEP : TRK_STEP;
            m_ctrl = clamp255(m_ctrl + v * mag);
            win_votes.push_back(v);
            if (win_votes.size() == WIN_LEN) begin
              s = win_votes.sum();
              if (s < 0) s = -s;
              win_votes.delete();
              if (m_phase == 2) begin
                if (s <= LOCK_THRESH) begin
                  m_quiet++;
                  if (m_quiet == LOCK_WINDOWS) begin
                    m_phase = 3; m_locked = 1; m_quiet = 0;
                  end
                end else begin
                  m_quiet = 0;
                end
              end else if (s >= UNLOCK_THRESH) begin
                m_phase = 2; m_locked = 0; m_quiet = 0;
              end
            end
          end
        end
        default: begin m_fault = 1; m_vco = 0; end
      endcase
    end
  endtask

  // scoreboard: expectation pushed at the edge, compared on the falling edge
  task automatic compare();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val("state",       32'(state),       32'(e[13:11]));
    check_val("vco_enable",  32'(vco_enable),  32'(e[10]));
    check_val("cdr_control", 32'(cdr_control), 32'(e[9:2]));
    check_val("cdr_locked",  32'(cdr_locked),  32'(e[1]));
    check_val("cdr_fault",   32'(cdr_fault),   32'(e[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back({3'(m_phase), m_vco, 8'(m_ctrl), m_locked, m_fault});
    @(negedge clk);
    compare();
  endtask

  // driver tasks
  task automatic drive_votes(input bit up, input bit dn);
    pd_up = up;
    pd_dn = dn;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_votes(0, 0);
      tick();
    end
  endtask

  // one net-zero pair of randomly chosen vote patterns
  task automatic quiet_pair();
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: begin drive_votes(1, 0); tick(); drive_votes(0, 1); tick(); end
      1: begin drive_votes(0, 1); tick(); drive_votes(1, 0); tick(); end
      2: begin drive_votes(1, 1); tick(); drive_votes(1, 1); tick(); end
      default: begin drive_votes(0, 0); tick(); drive_votes(0, 0); tick(); end
    endcase
  endtask

  task automatic wait_phase(input string tag, input int ph, input int budget);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      quiet_pair();
      n += 2;
    end
    check_val(tag, 32'(m_phase), 32'(ph));
  endtask

  // restart the loop with the VCO already ready; returns at first ACQUIRE cycle
  task automatic restart_ready();
    int n;
    cdr_en = 0; vco_ready = 1; drive_votes(0, 0);
    tick(); tick(); tick();
    cdr_en = 1;
    n = 0;
    while (m_phase != 2 && n < 10) begin
      tick();
      n++;
    end
    check_val("restart_acquire", 32'(state), 2);
  endtask

  initial begin
    // reset state
    tick(); tick();
    check_val("rst_state", 32'(state), 0);
    check_val("rst_ctrl", 32'(cdr_control), CENTER);
    rst = 1'b0;
    run_idle(3);

    // startup with delayed vco_ready
    cdr_en = 1;
    run_idle(20);
    check_val("start_wait_state", 32'(state), 1);
    check_val("start_wait_vco", 32'(vco_enable), 1);
    vco_ready = 1;
    run_idle(5);
    check_val("acq_entry_state", 32'(state), 2);
    check_val("acq_entry_ctrl", 32'(cdr_control), CENTER);

    // saturation both ways
    for (int i = 0; i < 40; i++) begin drive_votes(1, 0); tick(); end
    check_val("sat_high", 32'(cdr_control), 255);
    for (int i = 0; i < 70; i++) begin drive_votes(0, 1); tick(); end
    check_val("sat_low", 32'(cdr_control), 0);

    // exact lock timing from a clean ACQUIRE entry
    restart_ready();
    for (int i = 0; i < 127; i++) quiet_pair();
    drive_votes(1, 0); tick();
    check_val("lock_early", 32'(cdr_locked), 0);
    drive_votes(0, 1); tick();
    check_val("lock_at_256", 32'(cdr_locked), 1);
    check_val("lock_state", 32'(state), 3);
    check_val("lock_ctrl", 32'(cdr_control), CENTER);

    // track step, then 20 net up votes drop lock at window end
    drive_votes(1, 0); tick();
    check_val("trk_step", 32'(cdr_control), CENTER + TRK_STEP);
    for (int i = 0; i < 19; i++) begin drive_votes(1, 0); tick(); end
    run_idle(43);
    check_val("unlock_early", 32'(cdr_locked), 1);
    run_idle(1);
    check_val("unlock_locked", 32'(cdr_locked), 0);
    check_val("unlock_state", 32'(state), 2);
    check_val("unlock_ctrl", 32'(cdr_control), CENTER + 20 * TRK_STEP);

    // random votes, including vco_ready dropouts
    for (int i = 0; i < 400; i++) begin
      drive_votes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) vco_ready = ~vco_ready;
      tick();
    end
    vco_ready = 1;
    run_idle(4);

    // relock, then vco_ready loss sends the loop back to START
    wait_phase("relock", 3, 1200);
    vco_ready = 0;
    run_idle(3);
    check_val("rdy_loss_state", 32'(state), 1);
    check_val("rdy_loss_ctrl", 32'(cdr_control), CENTER);
    vco_ready = 1;
    run_idle(4);

    // cdr_en drop mid-ACQUIRE
    for (int i = 0; i < 10; i++) quiet_pair();
    check_val("pre_drop_state", 32'(state), 2);
    cdr_en = 0; drive_votes(1, 0);
    tick();
    check_val("en_drop_state", 32'(state), 0);
    check_val("en_drop_vco", 32'(vco_enable), 0);
    check_val("en_drop_ctrl", 32'(cdr_control), CENTER);

`ifdef SERDESPHY_CDR_FREEZE_EN
    restart_ready();
    for (int i = 0; i < 3; i++) begin drive_votes(1, 0); tick(); end
    cdr_freeze = 1;
    for (int i = 0; i < 20; i++) begin drive_votes(1, 0); tick(); end
    check_val("freeze_ctrl", 32'(cdr_control), CENTER + 3 * ACQ_STEP);
    cdr_freeze = 0;
    run_idle(2);
`endif

    // async reset mid-TRACK
    restart_ready();
    wait_phase("track_for_rst", 3, 600);
    #2 rst = 1;
    #1;
    check_val("async_rst_state", 32'(state), 0);
    check_val("async_rst_locked", 32'(cdr_locked), 0);
    check_val("async_rst_vco", 32'(vco_enable), 0);
    check_val("async_rst_ctrl", 32'(cdr_control), CENTER);
    model_reset();
    run_idle(3);
    rst = 0;

    // VCO never ready: timeout fault, cleared by cdr_en
    cdr_en = 0; vco_ready = 0;
    run_idle(3);
    cdr_en = 1;
    run_idle(1024);
    check_val("fault_early", 32'(cdr_fault), 0);
    run_idle(1);
    check_val("fault_set", 32'(cdr_fault), 1);
    check_val("fault_vco", 32'(vco_enable), 0);
    check_val("fault_state", 32'(state), 4);
    run_idle(5);
    cdr_en = 0;
    run_idle(1);
    check_val("fault_clear", 32'(cdr_fault), 0);
    check_val("fault_idle", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
